// File: rtl/alu_accum_ctrl_pkg.sv
// Shared opcode and FSM state encodings for the accumulating ALU controller.
package alu_accum_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_DEC = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_accum_ctrl_if.sv
// Command/result bundle of alu_accum_ctrl plus status and FSM debug view.
// Handshake: a transfer happens on a rising edge where valid && ready; a
// producer holds its payload stable while valid is high and ready is low.
interface alu_accum_ctrl_if
  import alu_accum_ctrl_pkg::*;
#(
    parameter int N = 4
) ();

    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_mode;
    logic         cmd_use_acc;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;

    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_carry;
    logic         res_zero;

    logic [N-1:0] acc_out;
    logic [7:0]   op_count;
    state_e       dbg_state;

    modport master (
        output cmd_valid, cmd_mode, cmd_use_acc, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero,
               acc_out, op_count, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_use_acc, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero,
               acc_out, op_count, dbg_state
    );

endinterface

// File: rtl/nBit_ALU.sv
// Purely combinational N-bit ALU with a per-operation carry/no-borrow flag.
module nBit_ALU
  import alu_accum_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  op_e          op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         carry
);

    logic [N:0] sum;

    always_comb begin
        sum   = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                y     = sum[N-1:0];
                carry = sum[N];
            end
            OP_SUB: begin
                y     = a - b;
                carry = (a >= b);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_INC: begin
                sum   = {1'b0, a} + {{N{1'b0}}, 1'b1};
                y     = sum[N-1:0];
                carry = sum[N];
            end
            OP_DEC: begin
                y     = a - {{(N-1){1'b0}}, 1'b1};
                carry = (a != '0);
            end
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_accum_ctrl.sv
// Three-state controller: capture a command, run it through the ALU for one
// cycle, then hold the result (and update the accumulator) until accepted.
module alu_accum_ctrl
  import alu_accum_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_accum_ctrl_if.slave bus
);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] res_q, res_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [N-1:0] alu_y;
    logic         alu_carry;

    nBit_ALU #(.N(N)) u_alu (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d    = op_e'(bus.cmd_mode);
                    a_d     = bus.cmd_use_acc ? acc_q : bus.cmd_a;
                    b_d     = bus.cmd_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Result, flags and accumulator all commit on this single edge.
                res_d   = alu_y;
                carry_d = alu_carry;
                zero_d  = (alu_y == '0);
                acc_d   = alu_y;
                cnt_d   = cnt_q + 8'd1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_DONE);
    assign bus.res_data  = res_q;
    assign bus.res_carry = carry_q;
    assign bus.res_zero  = zero_q;
    assign bus.acc_out   = acc_q;
    assign bus.op_count  = cnt_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_accum_ctrl.sv
// Directed self-checking bench for alu_accum_ctrl at N = 4.
module tb_alu_accum_ctrl;
  import alu_accum_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_ops;

  alu_accum_ctrl_if #(.N(4)) bus ();

  alu_accum_ctrl #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drives one command and stops in DONE with the result checked
  task automatic send_cmd(input logic [2:0] mode, input logic use_acc,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] exp_d, input logic exp_c,
                          input logic exp_z, input string tag);
    @(negedge clk);
    check({tag, ".cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_mode    = mode;
    bus.cmd_use_acc = use_acc;
    bus.cmd_a       = a;
    bus.cmd_b       = b;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, ".exec_valid"}, bus.res_valid, 0);
    check({tag, ".exec_ready"}, bus.cmd_ready, 0);
    @(negedge clk);
    n_ops++;
    check({tag, ".res_valid"}, bus.res_valid, 1);
    check({tag, ".res_data"},  bus.res_data,  exp_d);
    check({tag, ".res_carry"}, bus.res_carry, exp_c);
    check({tag, ".res_zero"},  bus.res_zero,  exp_z);
    check({tag, ".acc_out"},   bus.acc_out,   exp_d);
    check({tag, ".op_count"},  bus.op_count,  n_ops & 255);
  endtask

  task automatic accept_res();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] mode, input logic use_acc,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_c,
                        input logic exp_z, input string tag);
    send_cmd(mode, use_acc, a, b, exp_d, exp_c, exp_z, tag);
    accept_res();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_ops    = 0;
    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_mode     = 3'd0;
    bus.cmd_use_acc  = 1'b0;
    bus.cmd_a        = 4'd0;
    bus.cmd_b        = 4'd0;
    bus.res_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst.res_valid", bus.res_valid, 0);
    check("rst.cmd_ready", bus.cmd_ready, 1);
    check("rst.acc_out",   bus.acc_out,   0);
    check("rst.op_count",  bus.op_count,  0);
    check("rst.res_data",  bus.res_data,  0);
    check("rst.state",     bus.dbg_state, ST_IDLE);

    run_op(3'b000, 1'b0, 4'd9,  4'd8, 4'd1,  1'b1, 1'b0, "add_9_8");
    run_op(3'b001, 1'b0, 4'd3,  4'd5, 4'd14, 1'b0, 1'b0, "sub_3_5");
    run_op(3'b001, 1'b0, 4'd5,  4'd5, 4'd0,  1'b1, 1'b1, "sub_5_5");
    run_op(3'b011, 1'b0, 4'd15, 4'd0, 4'd15, 1'b0, 1'b0, "or_load15");
    run_op(3'b110, 1'b1, 4'd3,  4'd0, 4'd0,  1'b1, 1'b1, "inc_acc15");
    run_op(3'b111, 1'b1, 4'd7,  4'd0, 4'd15, 1'b0, 1'b0, "dec_acc0");

    // backpressure: new command offered while result is held
    send_cmd(3'b000, 1'b0, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, "bp_add");
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 3'b110;
    bus.cmd_a     = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.res_valid", bus.res_valid, 1);
      check("bp.res_data",  bus.res_data,  5);
      check("bp.cmd_ready", bus.cmd_ready, 0);
      check("bp.op_count",  bus.op_count,  n_ops);
    end
    bus.cmd_valid = 1'b0;
    accept_res();
    @(negedge clk);
    check("bp.after_ready", bus.cmd_ready, 1);
    check("bp.after_acc",   bus.acc_out,   5);
    check("bp.after_count", bus.op_count,  n_ops);

    run_op(3'b101, 1'b0, 4'd15, 4'd0,  4'd0, 1'b0, 1'b1, "not_15");
    run_op(3'b010, 1'b0, 4'd12, 4'd10, 4'd8, 1'b0, 1'b0, "and_12_10");
    run_op(3'b100, 1'b0, 4'd12, 4'd10, 4'd6, 1'b0, 1'b0, "xor_12_10");
    run_op(3'b000, 1'b1, 4'd0,  4'd4,  4'd10, 1'b0, 1'b0, "add_acc6_4");

    // drive op_count through 255 -> 0
    while (n_ops < 256)
      run_op(3'b010, 1'b0, 4'd5, 4'd10, 4'd0, 1'b0, 1'b1, "wrap_and");
    @(negedge clk);
    check("wrap.op_count", bus.op_count, 0);

    // reset while holding a result
    send_cmd(3'b000, 1'b0, 4'd7, 4'd1, 4'd8, 1'b0, 1'b0, "rstdone_add");
    rst_n = 1'b0;
    #1;
    check("rstdone.async_valid", bus.res_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_ops = 0;
    @(negedge clk);
    check("rstdone.res_valid", bus.res_valid, 0);
    check("rstdone.cmd_ready", bus.cmd_ready, 1);
    check("rstdone.acc_out",   bus.acc_out,   0);
    check("rstdone.op_count",  bus.op_count,  0);
    check("rstdone.res_data",  bus.res_data,  0);

    // reset while executing: nothing may commit
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 3'b000;
    bus.cmd_use_acc = 1'b0;
    bus.cmd_a     = 4'd6;
    bus.cmd_b     = 4'd6;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rstexec.state", bus.dbg_state, ST_EXEC);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstexec.state_idle", bus.dbg_state, ST_IDLE);
    check("rstexec.acc_out",    bus.acc_out,   0);
    check("rstexec.op_count",   bus.op_count,  0);
    check("rstexec.res_data",   bus.res_data,  0);

    run_op(3'b000, 1'b1, 4'd9, 4'd3, 4'd3, 1'b0, 1'b0, "post_rst_acc_add");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
